// File: rtl/apb_arb_pkg.sv
// Shared encodings and FSM states for the APB request arbiter.
// Imported by the arbiter top.
package apb_arb_pkg;

  localparam logic [1:0] ENC_WR = 2'b01;
  localparam logic [1:0] ENC_RD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  function automatic logic enc_legal(input logic [1:0] enc);
    return (enc == ENC_WR) || (enc == ENC_RD);
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Round-robin one-hot picker: first set request at or above ptr, wrapping to 0.
// Purely combinational; no backpressure.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic found;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[wrap_idx(ptr, k)]) begin
        found                 = 1'b1;
        gnt[wrap_idx(ptr, k)] = 1'b1;
        idx                   = wrap_idx(ptr, k);
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters, with pready timeout.
// Grant one cycle after request; requests wait while busy; response is a one-cycle pulse.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int TMO  = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_enc,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic [NREQ-1:0]   grant,
  output logic              trf_valid,
  output logic [1:0]        trf_enc,
  output logic [AW-1:0]     trf_addr,
  output logic [DW-1:0]     trf_wdata,
  input  logic              psel,
  input  logic              penable,
  input  logic              pready,
  input  logic [DW-1:0]     prdata
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TMO);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [1:0]      sel_enc;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            bus_setup;
  logic            bus_done;
  logic            tmo_hit;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_enc   = req_enc[2*int'(pick_idx) +: 2];
  assign sel_addr  = req_addr[AW*int'(pick_idx) +: AW];
  assign sel_wdata = req_wdata[DW*int'(pick_idx) +: DW];

  assign bus_setup = psel && !penable;
  assign bus_done  = psel && penable && pready;
  // This access cycle would bring the wait counter to TMO-1.
  assign tmo_hit   = (cnt_q == CW'(TMO - 2));

  always_ff @(posedge pclk) begin
    if (!prstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = enc_legal(sel_enc) ? ISSUE : RESP;
      ISSUE:   if (bus_setup) state_d = ACCESS;
      ACCESS:  if (bus_done || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      trf_valid <= 1'b0;
      trf_enc   <= '0;
      trf_addr  <= '0;
      trf_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_gnt;
            idx_q     <= pick_idx;
            trf_enc   <= sel_enc;
            trf_addr  <= sel_addr;
            trf_wdata <= sel_wdata;
            if (enc_legal(sel_enc)) begin
              trf_valid <= 1'b1;
            end else begin
              // Illegal command never touches the bus; answer straight away.
              rsp_valid <= pick_gnt;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (bus_setup) begin
            trf_valid <= 1'b0;
            cnt_q     <= '0;
          end
        end
        ACCESS: begin
          if (bus_done) begin
            rsp_valid <= grant;
            rsp_err   <= 1'b0;
            rsp_rdata <= (trf_enc == ENC_RD) ? prdata : '0;
          end else if (tmo_hit) begin
            rsp_valid <= grant;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          grant <= '0;
          ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter: acts as APB master/slave and checks
// grants and responses against a round-robin reference model.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TMO  = 16;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] RD = 2'b10;

  logic pclk = 1'b0;
  logic prstn;
  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_enc;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [NREQ-1:0]    grant;
  logic               trf_valid;
  logic [1:0]         trf_enc;
  logic [AW-1:0]      trf_addr;
  logic [DW-1:0]      trf_wdata;
  logic               psel, penable, pready;
  logic [DW-1:0]      prdata;

  logic [1:0]    c_enc[NREQ];
  logic [AW-1:0] c_addr[NREQ];
  logic [DW-1:0] c_wdata[NREQ];

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_enc[2*g +: 2]    = c_enc[g];
    assign req_addr[AW*g +: AW] = c_addr[g];
    assign req_wdata[DW*g +: DW] = c_wdata[g];
  end

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .pclk(pclk), .prstn(prstn),
    .req_valid(req_valid), .req_enc(req_enc), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .grant(grant),
    .trf_valid(trf_valid), .trf_enc(trf_enc), .trf_addr(trf_addr), .trf_wdata(trf_wdata),
    .psel(psel), .penable(penable), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_grant"}, 32'(grant), 0);
    check_val({tag, "_trf_valid"}, 32'(trf_valid), 0);
    check_val({tag, "_trf_enc"}, 32'(trf_enc), 0);
    check_val({tag, "_trf_addr"}, 32'(trf_addr), 0);
    check_val({tag, "_trf_wdata"}, 32'(trf_wdata), 0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_val({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check_val({tag, "_rsp_err"}, 32'(rsp_err), 0);
  endtask

  // Reference: first pending requester at or after the pointer, wrapping.
  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] e, input logic [AW-1:0] a,
                         input logic [DW-1:0] w);
    c_enc[i] = e; c_addr[i] = a; c_wdata[i] = w; req_valid[i] = 1'b1;
  endtask

  task automatic new_cmd(input int i);
    logic [1:0] e;
    if ($urandom_range(0, 7) == 0) e = $urandom_range(0, 1) ? 2'b11 : 2'b00;
    else                           e = $urandom_range(0, 1) ? WR : RD;
    set_req(i, e, AW'($urandom), DW'($urandom));
  endtask

  task automatic reset_dut();
    prstn = 1'b0; psel = 1'b0; penable = 1'b0; pready = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge pclk);
    check_quiet("reset");
    prstn = 1'b1;
    ptr_m = 0;
  endtask

  // One complete transfer starting from an idle DUT with at least one request pending.
  task automatic xfer(input int ws, input bit hang, input logic [DW-1:0] rd, input bit mess);
    int win, n;
    logic [1:0]    e;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    win = model_pick();
    if (win < 0) win = 0;
    e = c_enc[win]; a = c_addr[win]; w = c_wdata[win];
    n = 0;
    @(negedge pclk);
    while (grant == '0 && n < 8) begin @(negedge pclk); n++; end
    check_val("grant", 32'(grant), 32'(1) << win);
    if (mess) begin
      if ($urandom_range(0, 1)) begin
        c_enc[win] = 2'($urandom); c_addr[win] = AW'($urandom); c_wdata[win] = DW'($urandom);
      end
      if ($urandom_range(0, 1)) req_valid[win] = 1'b0;
    end
    if (e != WR && e != RD) begin
      check_val("ill_trf_valid", 32'(trf_valid), 0);
      exp_err = 1'b1;
      exp_rd  = '0;
    end else begin
      check_val("trf_valid", 32'(trf_valid), 1);
      check_val("trf_enc", 32'(trf_enc), 32'(e));
      check_val("trf_addr", 32'(trf_addr), 32'(a));
      check_val("trf_wdata", 32'(trf_wdata), 32'(w));
      psel = 1'b1; penable = 1'b0;
      @(negedge pclk);
      check_val("trf_drop", 32'(trf_valid), 0);
      penable = 1'b1; prdata = rd;
      pready  = !hang && (ws == 0);
      n = 0;
      @(negedge pclk);
      while (rsp_valid == '0 && n < 3*TMO) begin
        n++;
        pready = !hang && (n >= ws);
        @(negedge pclk);
      end
      check_val("acc_cycles", 32'(n + 1), hang ? 32'(TMO - 1) : 32'(ws + 1));
      psel = 1'b0; penable = 1'b0; pready = 1'b0;
      exp_err = hang;
      exp_rd  = (!hang && e == RD) ? rd : '0;
    end
    check_val("rsp_valid", 32'(rsp_valid), 32'(1) << win);
    check_val("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    req_valid[win] = 1'b0;
    ptr_m = (win + 1) % NREQ;
    @(negedge pclk);
    check_val("rsp_pulse", 32'(rsp_valid), 0);
    check_val("grant_clr", 32'(grant), 0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin c_enc[i] = '0; c_addr[i] = '0; c_wdata[i] = '0; end
    prdata = '0;
    reset_dut();

    // Single write and single read with two wait states.
    set_req(0, WR, 8'h05, 8'hA5);
    xfer(0, 1'b0, 8'h77, 1'b0);
    set_req(2, RD, 8'h10, 8'h00);
    xfer(2, 1'b0, 8'h3C, 1'b0);

    // Contention from reset, then requester 0 comes back and must wait for 3.
    reset_dut();
    set_req(0, WR, 8'h20, 8'h11);
    set_req(1, RD, 8'h21, 8'h22);
    set_req(3, WR, 8'h23, 8'h33);
    xfer(1, 1'b0, 8'h44, 1'b0);
    set_req(0, RD, 8'h24, 8'h55);
    xfer(0, 1'b0, 8'h66, 1'b0);
    xfer(3, 1'b0, 8'h77, 1'b0);
    xfer(0, 1'b0, 8'h88, 1'b0);

    // Timeout, then a normal transfer.
    set_req(3, RD, 8'h30, 8'h00);
    xfer(0, 1'b1, 8'h99, 1'b0);
    set_req(0, RD, 8'h31, 8'h00);
    xfer(1, 1'b0, 8'h5A, 1'b0);

    // Illegal encoding.
    set_req(1, 2'b11, 8'h40, 8'h41);
    xfer(0, 1'b0, 8'h00, 1'b0);

    // Reset while waiting in the access phase.
    set_req(2, RD, 8'h50, 8'h00);
    begin
      int n;
      n = 0;
      @(negedge pclk);
      while (grant == '0 && n < 8) begin @(negedge pclk); n++; end
      check_val("rst_grant", 32'(grant), 32'b0100);
      psel = 1'b1; penable = 1'b0;
      @(negedge pclk);
      penable = 1'b1; pready = 1'b0;
      repeat (3) @(negedge pclk);
      prstn = 1'b0;
      @(negedge pclk);
      check_quiet("midrst");
      prstn = 1'b1; psel = 1'b0; penable = 1'b0; req_valid = '0;
      ptr_m = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge pclk);
        check_val("midrst_no_rsp", 32'(rsp_valid), 0);
      end
    end
    // Pointer must be back at 0: 1 wins over 3.
    set_req(1, WR, 8'h60, 8'h61);
    set_req(3, WR, 8'h62, 8'h63);
    xfer(0, 1'b0, 8'h00, 1'b0);
    xfer(0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) new_cmd(i);
      if (req_valid == '0) new_cmd($urandom_range(0, NREQ - 1));
      xfer($urandom_range(0, 3), $urandom_range(0, 9) == 0, DW'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin arbiter sharing one APB master between NREQ requesters. Selects one pending request, drives the master's transfer interface (trf_valid/trf_enc/trf_addr/trf_wdata), monitors the APB bus for completion and returns a per-requester response with read data. Adds a pready timeout so a hung slave cannot lock the bus. Sits between client logic and APB_master, clocked by pclk.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 8, address width
DW, 8, data width
TMO, 16, max cycles waiting for pready in access phase before error (>=2)

Ports:
pclk  in  1  clock
prstn  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request, level, held until rsp_valid for that requester
req_enc  in  2*NREQ  per-requester encoding; 2'b01 write, 2'b10 read, others illegal
req_addr  in  AW*NREQ  per-requester address, slice i = [AW*i +: AW]
req_wdata  in  DW*NREQ  per-requester write data
rsp_valid  out  NREQ  one-hot, single-cycle completion pulse to the granted requester
rsp_rdata  out  DW  read data, valid with rsp_valid (0 on write or error)
rsp_err  out  1  error flag, valid with rsp_valid
grant  out  NREQ  one-hot current owner, 0 when idle
trf_valid  out  1  to APB master
trf_enc  out  2  to APB master
trf_addr  out  AW  to APB master
trf_wdata  out  DW  to APB master
psel  in  1  APB bus monitor
penable  in  1  APB bus monitor
pready  in  1  APB bus monitor
prdata  in  DW  APB bus monitor

Behaviour:
- Reset (prstn=0 at pclk rise): state IDLE, rr pointer=0, grant=0, trf_valid=0, trf_enc/addr/wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- States: IDLE, ISSUE, ACCESS, RESP.
- IDLE: if any req_valid, pick first set bit searching from rr pointer upward with wrap (NREQ-1 -> 0); register grant and latch that requester's enc/addr/wdata. Illegal enc -> RESP with rsp_err=1, no bus activity. Legal -> ISSUE, trf_valid=1 from next cycle.
- ISSUE: hold trf_valid=1 and command stable. On psel=1 && penable=0 (setup phase seen), deassert trf_valid next cycle, go ACCESS, clear counter.
- ACCESS: completion = psel && penable && pready. On completion: capture prdata if read (else 0), rsp_err=0, go RESP. Else counter++; when counter reaches TMO-1 without completion: rsp_err=1, rsp_rdata=0, go RESP.
- RESP: rsp_valid[granted]=1 for exactly one cycle with rsp_rdata/rsp_err; rr pointer = granted index+1 (wrapped); grant cleared; return to IDLE. Earliest next grant is the cycle after RESP (one idle cycle between transfers; accepted throughput cost).
- Latched command is immune to requester changes after grant; dropping req_valid mid-transfer does not abort it, response still pulsed.
- Requests arriving while busy wait; simultaneous requests resolved by rr pointer only. No starvation: each pending requester served within NREQ transfers.
- rsp_rdata/rsp_err hold last value between pulses; consumers qualify with rsp_valid.
- Reset mid-transfer: all state cleared immediately, no response pulse issued.

Decomposition:
- Package apb_arb_pkg: encoding constants ENC_WR=2'b01, ENC_RD=2'b10; state enum IDLE/ISSUE/ACCESS/RESP.
- Sub-module rr_pick: combinational round-robin one-hot picker (inputs req vector, pointer; outputs one-hot and index). Used once; unit-testable separately.

Test Plan:
- Single write: req_valid[0]=1, enc=01, addr=8'h05, wdata=8'hA5; slave pready=1 first access cycle -> trf_addr=05/trf_wdata=A5 driven, rsp_valid=4'b0001 one cycle, rsp_err=0, rsp_rdata=0.
- Single read: req 2 enc=10 addr=8'h10, prdata=8'h3C with pready after 2 wait states -> rsp_valid=4'b0100, rsp_rdata=3C, rsp_err=0.
- Contention: req 0,1,3 asserted together from reset -> grant order 0,1,3, then with req 0 reasserted order continues 0 only after 3 (pointer wrap verified).
- Timeout: TMO=16, pready held 0 -> after 15 access cycles rsp_valid pulses with rsp_err=1, rsp_rdata=0; next request proceeds normally.
- Illegal encoding: req 1 enc=2'b11 -> trf_valid never asserts, rsp_valid=4'b0010 with rsp_err=1.
- Reset mid-ACCESS: prstn=0 one cycle during wait state -> all outputs 0 next cycle, no rsp_valid, pointer=0.
